// File: rtl/uzorak_sastavljac.sv
// rtl/uzorak_sastavljac.sv - packs activation words into samples for the output neurons
// Assembly register collects one frame while the output register waits for downstream.
module uzorak_sastavljac #(
  parameter int BROJ_ZNACAJKI = 5,
  parameter int SIRINA        = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [SIRINA-1:0]                 ulaz_podatak,
  input  logic                              ulaz_valid,
  input  logic                              ulaz_zadnji,
  output logic                              ulaz_ready,
  output logic [SIRINA*BROJ_ZNACAJKI-1:0]   uzorak,
  output logic                              uzorak_valid,
  input  logic                              uzorak_ready,
  output logic                              greska,
  output logic [7:0]                        broj_odbacenih
);

  localparam int KW = (BROJ_ZNACAJKI > 1) ? $clog2(BROJ_ZNACAJKI) : 1;
  localparam logic [KW-1:0] ZADNJI_IDX = KW'(BROJ_ZNACAJKI - 1);

  typedef enum logic [1:0] {
    SKUPLJANJE = 2'd0,
    RESINK     = 2'd1,
    PUN        = 2'd2
  } stanje_t;

  stanje_t                           stanje_q, stanje_d;
  logic [KW-1:0]                     k_q, k_d;
  logic [SIRINA*BROJ_ZNACAJKI-1:0]   sklop_q;
  logic [SIRINA*BROJ_ZNACAJKI-1:0]   uzorak_q;
  logic                              uzorak_valid_q;
  logic                              greska_q, greska_d;
  logic [7:0]                        broj_q;
  logic                              prihvat;
  logic                              upis;
  logic                              punjenje;

  assign ulaz_ready     = (stanje_q != PUN);
  assign prihvat        = ulaz_valid & ulaz_ready;
  assign uzorak         = uzorak_q;
  assign uzorak_valid   = uzorak_valid_q;
  assign greska         = greska_q;
  assign broj_odbacenih = broj_q;

  always_comb begin
    stanje_d = stanje_q;
    k_d      = k_q;
    upis     = 1'b0;
    greska_d = 1'b0;
    punjenje = 1'b0;
    case (stanje_q)
      SKUPLJANJE: begin
        if (prihvat) begin
          if (k_q == ZADNJI_IDX) begin
            k_d = '0;
            if (ulaz_zadnji) begin
              upis     = 1'b1;
              stanje_d = PUN;
            end else begin
              // Overlong frame: drop the rest of it up to its last word.
              greska_d = 1'b1;
              stanje_d = RESINK;
            end
          end else if (ulaz_zadnji) begin
            k_d      = '0;
            greska_d = 1'b1;
          end else begin
            upis = 1'b1;
            k_d  = k_q + 1'b1;
          end
        end
      end
      RESINK: begin
        if (prihvat && ulaz_zadnji) stanje_d = SKUPLJANJE;
      end
      PUN: begin
        if (!uzorak_valid_q || uzorak_ready) begin
          punjenje = 1'b1;
          stanje_d = SKUPLJANJE;
        end
      end
      default: stanje_d = SKUPLJANJE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stanje_q       <= SKUPLJANJE;
      k_q            <= '0;
      sklop_q        <= '0;
      uzorak_q       <= '0;
      uzorak_valid_q <= 1'b0;
      greska_q       <= 1'b0;
      broj_q         <= '0;
    end else begin
      stanje_q <= stanje_d;
      k_q      <= k_d;
      greska_q <= greska_d;
      if (upis) sklop_q[SIRINA*int'(k_q) +: SIRINA] <= ulaz_podatak;
      // A fresh load takes priority over the downstream consuming the old sample.
      if (punjenje) begin
        uzorak_q       <= sklop_q;
        uzorak_valid_q <= 1'b1;
      end else if (uzorak_ready) begin
        uzorak_valid_q <= 1'b0;
      end
      if (greska_d && (broj_q != 8'hFF)) broj_q <= broj_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_uzorak_sastavljac.sv
// tb/tb_uzorak_sastavljac.sv - directed self-checking bench for uzorak_sastavljac
module tb_uzorak_sastavljac;

  logic        clk;
  logic        rst_n;
  logic [15:0] ulaz_podatak;
  logic        ulaz_valid;
  logic        ulaz_zadnji;
  logic        ulaz_ready;
  logic [79:0] uzorak;
  logic        uzorak_valid;
  logic        uzorak_ready;
  logic        greska;
  logic [7:0]  broj_odbacenih;

  int checks_total  = 0;
  int checks_passed = 0;
  int greska_cnt    = 0;
  int g0;
  logic [79:0] ocekivano_a;
  logic [79:0] ocekivano_b;

  uzorak_sastavljac #(.BROJ_ZNACAJKI(5), .SIRINA(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ulaz_podatak   (ulaz_podatak),
    .ulaz_valid     (ulaz_valid),
    .ulaz_zadnji    (ulaz_zadnji),
    .ulaz_ready     (ulaz_ready),
    .uzorak         (uzorak),
    .uzorak_valid   (uzorak_valid),
    .uzorak_ready   (uzorak_ready),
    .greska         (greska),
    .broj_odbacenih (broj_odbacenih)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (greska) greska_cnt <= greska_cnt + 1;

  function automatic logic [79:0] okvir(input logic [15:0] baza);
    logic [79:0] v;
    for (int i = 0; i < 5; i++) v[16*i +: 16] = baza + 16'(i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic z);
    int w;
    ulaz_podatak = d;
    ulaz_valid   = 1'b1;
    ulaz_zadnji  = z;
    w = 0;
    while (!ulaz_ready && w < 50) begin
      tick();
      w++;
    end
    if (!ulaz_ready) chk("send_timeout", {79'b0, ulaz_ready}, 80'd1);
    tick();
    ulaz_valid  = 1'b0;
    ulaz_zadnji = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [15:0] baza);
    for (int i = 0; i < n; i++) send_word(baza + 16'(i), (i == n - 1));
  endtask

  task automatic wait_valid(input string tag, input logic [79:0] exp);
    int w;
    w = 0;
    while (!uzorak_valid && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, {79'b0, uzorak_valid}, 80'd1);
    chk({tag, "_data"}, uzorak, exp);
  endtask

  initial begin
    rst_n        = 1'b0;
    ulaz_podatak = '0;
    ulaz_valid   = 1'b0;
    ulaz_zadnji  = 1'b0;
    uzorak_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    chk("rst_valid", {79'b0, uzorak_valid}, 80'd0);
    chk("rst_uzorak", uzorak, 80'd0);
    chk("rst_greska", {79'b0, greska}, 80'd0);
    chk("rst_broj", {72'b0, broj_odbacenih}, 80'd0);
    chk("rst_ready", {79'b0, ulaz_ready}, 80'd1);

    // 1: basic frame, latency and single-cycle valid
    send_frame(5, 16'h0001);
    chk("t1_valid_n", {79'b0, uzorak_valid}, 80'd0);
    chk("t1_bubble", {79'b0, ulaz_ready}, 80'd0);
    tick();
    chk("t1_valid_n1", {79'b0, uzorak_valid}, 80'd1);
    chk("t1_data", uzorak, 80'h0005_0004_0003_0002_0001);
    tick();
    chk("t1_valid_drop", {79'b0, uzorak_valid}, 80'd0);
    chk("t1_retain", uzorak, 80'h0005_0004_0003_0002_0001);

    // 2: downstream stalled, two frames buffered then drained in order
    uzorak_ready = 1'b0;
    ocekivano_a = okvir(16'h0A01);
    ocekivano_b = okvir(16'h0B01);
    send_frame(5, 16'h0A01);
    send_frame(5, 16'h0B01);
    chk("t2_full", {79'b0, ulaz_ready}, 80'd0);
    chk("t2_a_held", uzorak, ocekivano_a);
    repeat (3) tick();
    chk("t2_a_stable", uzorak, ocekivano_a);
    chk("t2_a_valid", {79'b0, uzorak_valid}, 80'd1);
    chk("t2_still_full", {79'b0, ulaz_ready}, 80'd0);
    uzorak_ready = 1'b1;
    tick();
    chk("t2_b_data", uzorak, ocekivano_b);
    chk("t2_b_valid", {79'b0, uzorak_valid}, 80'd1);
    chk("t2_ready_back", {79'b0, ulaz_ready}, 80'd1);
    tick();
    chk("t2_drained", {79'b0, uzorak_valid}, 80'd0);

    // 3: short frame discarded
    g0 = greska_cnt;
    send_frame(3, 16'h0301);
    chk("t3_greska", {79'b0, greska}, 80'd1);
    chk("t3_broj", {72'b0, broj_odbacenih}, 80'd1);
    chk("t3_no_valid", {79'b0, uzorak_valid}, 80'd0);
    tick();
    chk("t3_greska_pulse", {79'b0, greska}, 80'd0);
    send_frame(5, 16'h0401);
    wait_valid("t3_next", okvir(16'h0401));
    chk("t3_pulses", 80'(greska_cnt - g0), 80'd1);
    tick();

    // 4: long frame, tail words dropped until zadnji
    g0 = greska_cnt;
    send_frame(7, 16'h0501);
    chk("t4_no_valid", {79'b0, uzorak_valid}, 80'd0);
    chk("t4_broj", {72'b0, broj_odbacenih}, 80'd2);
    send_frame(5, 16'h0601);
    wait_valid("t4_next", okvir(16'h0601));
    chk("t4_pulses", 80'(greska_cnt - g0), 80'd1);
    tick();

    // 5: asynchronous reset mid-frame with a sample pending
    uzorak_ready = 1'b0;
    send_frame(5, 16'h0701);
    wait_valid("t5_pending", okvir(16'h0701));
    send_word(16'h0801, 1'b0);
    send_word(16'h0802, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {79'b0, uzorak_valid}, 80'd0);
    chk("t5_rst_uzorak", uzorak, 80'd0);
    chk("t5_rst_broj", {72'b0, broj_odbacenih}, 80'd0);
    chk("t5_rst_greska", {79'b0, greska}, 80'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    uzorak_ready = 1'b1;
    tick();
    send_frame(5, 16'h0901);
    wait_valid("t5_after", okvir(16'h0901));
    chk("t5_broj_after", {72'b0, broj_odbacenih}, 80'd0);
    tick();

    // 6: counter saturation with back-to-back one-word short frames
    g0 = greska_cnt;
    for (int i = 0; i < 255; i++) send_word(16'(i), 1'b1);
    tick();
    chk("t6_broj_255", {72'b0, broj_odbacenih}, 80'd255);
    for (int i = 0; i < 5; i++) send_word(16'(i), 1'b1);
    tick();
    chk("t6_broj_sat", {72'b0, broj_odbacenih}, 80'd255);
    chk("t6_pulses", 80'(greska_cnt - g0), 80'd260);
    chk("t6_no_valid", {79'b0, uzorak_valid}, 80'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
